arm_multicycle_ctrl: RTL and testbench

Multicycle control unit and program-counter owner for the ARM-subset core. It latches each fetched instruction, checks its condition field against the internal NZCV flags, and sequences FETCH→DECODE→EXECUTE→WRITEBACK. It drives the register-file read/write addresses, write enable, InstrCode, and the R15 (PC+8) value. It sits directly upstream of the register file and consumes the ALU flags and result from the datapath.

---
 rtl/arm_multicycle_ctrl_if.sv | 51 +++++
 rtl/arm_multicycle_ctrl.sv | 269 ++++++++++++++++++++++++++
 tb/tb_arm_multicycle_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arm_multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : arm_multicycle_ctrl_if
// Description : Bundle of controller <-> datapath / register-file signals for
//               the ARM-subset multicycle core.
//               master : the control unit (drives PC, addresses, strobes)
//               slave  : the datapath side (drives RD, ALUFlags, Result)
// Signals     : RD[31:0]        instruction memory read data
//               ALUFlags[3:0]   {N,Z,C,V} from the ALU
//               Result[31:0]    datapath result (ALU or memory)
//               PC[31:0]        fetch/data address register
//               R15[31:0]       PC+4
//               A1/A2/A3[3:0]   register-file addresses
//               WE3             register-file write enable
//               InstrCode[2:0]  instruction class for the datapath
//               IRWrite, MemWrite, AdrSrc, ResultSrc  strobes
//               ALUSrcB[1:0]    ALU B operand select
//               ALUCmd[3:0]     ALU operation
// Revision    : 1.0 - initial release
// ============================================================================
interface arm_multicycle_ctrl_if;
    logic [31:0] RD;
    logic [3:0]  ALUFlags;
    logic [31:0] Result;
    logic [31:0] PC;
    logic [31:0] R15;
    logic [3:0]  A1;
    logic [3:0]  A2;
    logic [3:0]  A3;
    logic        WE3;
    logic [2:0]  InstrCode;
    logic        IRWrite;
    logic        MemWrite;
    logic        AdrSrc;
    logic [1:0]  ALUSrcB;
    logic [3:0]  ALUCmd;
    logic        ResultSrc;

    modport master (
        input  RD, ALUFlags, Result,
        output PC, R15, A1, A2, A3, WE3, InstrCode,
               IRWrite, MemWrite, AdrSrc, ALUSrcB, ALUCmd, ResultSrc
    );

    modport slave (
        output RD, ALUFlags, Result,
        input  PC, R15, A1, A2, A3, WE3, InstrCode,
               IRWrite, MemWrite, AdrSrc, ALUSrcB, ALUCmd, ResultSrc
    );
endinterface
`default_nettype wire

// File: rtl/arm_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : arm_multicycle_ctrl
// Description : Multicycle control unit and PC owner for the ARM-subset core.
//               Latches the fetched instruction, evaluates its condition
//               field against the internal NZCV flags and sequences
//               FETCH -> DECODE -> EXECUTE -> WRITEBACK.
// Ports       : CLK     system clock, all state on posedge
//               RESETn  asynchronous active-low reset
//               bus     arm_multicycle_ctrl_if.master (see interface header)
// Parameters  : RESET_PC  PC value loaded on reset
// Revision    : 1.0 - initial release
// ============================================================================
module arm_multicycle_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire                   CLK,
    input  wire                   RESETn,
    arm_multicycle_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [31:0] pc_q;
    // Only the instruction fields the controller consumes are kept:
    // ir_hi_q holds Instr[31:12], ir_rm_q holds Instr[3:0]. The immediate
    // bits in between are consumed by the datapath directly from memory.
    logic [19:0] ir_hi_q;
    logic [3:0]  ir_rm_q;
    logic [3:0]  flags_q;

    // Strobes are registered from the next state so they are clean for the
    // full cycle of the state they belong to.
    logic irwrite_q,   irwrite_d;
    logic we3_q,       we3_d;
    logic memwrite_q,  memwrite_d;
    logic adrsrc_q,    adrsrc_d;
    logic resultsrc_q, resultsrc_d;

    // ------------------------------------------------------------------
    // Instruction field extraction
    // ------------------------------------------------------------------
    logic [3:0] w_cond;
    logic [1:0] w_op;
    logic       w_ibit;
    logic [3:0] w_cmd;
    logic       w_ubit;
    logic       w_sl;
    logic       w_link;
    logic [3:0] w_rn;
    logic [3:0] w_rd;

    assign w_cond = ir_hi_q[19:16];
    assign w_op   = ir_hi_q[15:14];
    assign w_ibit = ir_hi_q[13];
    assign w_cmd  = ir_hi_q[12:9];
    assign w_link = ir_hi_q[12];
    assign w_ubit = ir_hi_q[11];
    assign w_sl   = ir_hi_q[8];
    assign w_rn   = ir_hi_q[7:4];
    assign w_rd   = ir_hi_q[3:0];

    // ------------------------------------------------------------------
    // Condition evaluation against the stored flags
    // ------------------------------------------------------------------
    logic w_n, w_z, w_c, w_v;
    logic w_cond_ok;

    assign {w_n, w_z, w_c, w_v} = flags_q;

    always_comb begin
        w_cond_ok = 1'b0;
        case (w_cond)
            4'b0000: w_cond_ok = w_z;
            4'b0001: w_cond_ok = ~w_z;
            4'b0010: w_cond_ok = w_c;
            4'b0011: w_cond_ok = ~w_c;
            4'b0100: w_cond_ok = w_n;
            4'b0101: w_cond_ok = ~w_n;
            4'b0110: w_cond_ok = w_v;
            4'b0111: w_cond_ok = ~w_v;
            4'b1000: w_cond_ok = w_c & ~w_z;
            4'b1001: w_cond_ok = ~w_c | w_z;
            4'b1010: w_cond_ok = (w_n == w_v);
            4'b1011: w_cond_ok = (w_n != w_v);
            4'b1100: w_cond_ok = ~w_z & (w_n == w_v);
            4'b1101: w_cond_ok = w_z | (w_n != w_v);
            4'b1110: w_cond_ok = 1'b1;
            default: w_cond_ok = 1'b0;
        endcase
    end

    // Compare/test opcodes (TST, TEQ, CMP, CMN) only affect flags.
    logic w_no_wb;
    assign w_no_wb = (w_cmd[3:2] == 2'b10);

    // ------------------------------------------------------------------
    // Combinational decode from IR (stable for the whole instruction)
    // ------------------------------------------------------------------
    logic [2:0] w_instr_code;
    logic [1:0] w_alusrcb;
    logic [3:0] w_alucmd;

    always_comb begin
        w_instr_code = 3'b110;
        if (w_cond_ok) begin
            case (w_op)
                OP_DP:   w_instr_code = {2'b00, w_ibit};
                OP_MEM:  w_instr_code = w_sl ? 3'b010 : 3'b011;
                OP_BR:   w_instr_code = w_link ? 3'b111 : 3'b100;
                default: w_instr_code = 3'b110;
            endcase
        end
    end

    always_comb begin
        w_alusrcb = 2'b00;
        case (w_op)
            OP_DP:   w_alusrcb = {1'b0, w_ibit};
            OP_MEM:  w_alusrcb = 2'b01;
            OP_BR:   w_alusrcb = 2'b10;
            default: w_alusrcb = 2'b00;
        endcase
    end

    always_comb begin
        w_alucmd = 4'b0100;
        if (w_op == OP_DP) begin
            w_alucmd = w_cmd;
        end else if ((w_op == OP_MEM) && !w_ubit) begin
            w_alucmd = 4'b0010;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (!w_cond_ok) begin
                    state_d = S_FETCH;
                end else begin
                    case (w_op)
                        OP_DP:   state_d = w_ibit ? S_EXECI : S_EXECR;
                        OP_MEM:  state_d = S_MEMADR;
                        OP_BR:   state_d = S_BRANCH;
                        default: state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR:   state_d = w_sl ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Strobe values for the state about to be entered. IR is already
    // stable whenever ALUWB is the next state, so w_no_wb is valid here.
    always_comb begin
        irwrite_d   = (state_d == S_FETCH);
        we3_d       = (state_d == S_MEMWB) ||
                      ((state_d == S_ALUWB) && !w_no_wb);
        memwrite_d  = (state_d == S_MEMWRITE);
        adrsrc_d    = (state_d == S_MEMREAD) || (state_d == S_MEMWB) ||
                      (state_d == S_MEMWRITE);
        resultsrc_d = (state_d == S_MEMWB);
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            ir_hi_q     <= 20'd0;
            ir_rm_q     <= 4'd0;
            flags_q     <= 4'd0;
            // Reset parks the FSM in FETCH, so IRWrite must be ready to
            // assert as soon as RESETn is released.
            irwrite_q   <= 1'b1;
            we3_q       <= 1'b0;
            memwrite_q  <= 1'b0;
            adrsrc_q    <= 1'b0;
            resultsrc_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            irwrite_q   <= irwrite_d;
            we3_q       <= we3_d;
            memwrite_q  <= memwrite_d;
            adrsrc_q    <= adrsrc_d;
            resultsrc_q <= resultsrc_d;

            case (state_q)
                S_FETCH: begin
                    ir_hi_q <= bus.RD[31:12];
                    ir_rm_q <= bus.RD[3:0];
                    pc_q    <= pc_q + 32'd4;
                end
                S_BRANCH: begin
                    pc_q <= bus.Result;
                end
                S_ALUWB: begin
                    if (w_sl) begin
                        flags_q <= bus.ALUFlags;
                    end
                end
                default: begin
                end
            endcase

            // A register-file write to R15 redirects the PC in the same
            // writeback cycle.
            if (we3_q && (w_rd == 4'd15)) begin
                pc_q <= bus.Result;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.PC        = pc_q;
    assign bus.R15       = pc_q + 32'd4;
    assign bus.A1        = (w_op == OP_BR) ? 4'd15 : w_rn;
    assign bus.A2        = ((w_op == OP_MEM) && !w_sl) ? w_rd : ir_rm_q;
    assign bus.A3        = w_rd;
    assign bus.InstrCode = w_instr_code;
    assign bus.ALUSrcB   = w_alusrcb;
    assign bus.ALUCmd    = w_alucmd;
    assign bus.ResultSrc = resultsrc_q;

    // Strobes are forced low for as long as RESETn is asserted, so a
    // pending memory write is dropped the instant reset arrives.
    assign bus.IRWrite   = irwrite_q  & RESETn;
    assign bus.WE3       = we3_q      & RESETn;
    assign bus.MemWrite  = memwrite_q & RESETn;
    assign bus.AdrSrc    = adrsrc_q   & RESETn;

endmodule
`default_nettype wire

// File: tb/tb_arm_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_arm_multicycle_ctrl
// Description : Self-checking bench for arm_multicycle_ctrl: directed vector
//               table, reset / wrap corner sequences and a randomized
//               instruction stream checked against an instruction-level
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arm_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    arm_multicycle_ctrl_if bus();

    arm_multicycle_ctrl #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .CLK    (clk),
        .RESETn (rst_n),
        .bus    (bus)
    );

    // Observation of one instruction, cycle counts and DECODE-cycle values.
    typedef struct {
        logic [31:0] cyc;
        logic [31:0] code;
        logic [31:0] we;
        logic [31:0] a3;
        logic [31:0] mw;
        logic [31:0] adr;
        logic [31:0] rs;
        logic [31:0] pc;
        logic [31:0] r15;
        logic [31:0] a1;
        logic [31:0] a2;
        logic [31:0] cmd;
        logic [31:0] srcb;
    } obs_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] res;
        logic [31:0] fl;
        logic [31:0] cyc;
        logic [31:0] code;
        logic [31:0] we;
        logic [31:0] a3;
        logic [31:0] mw;
        logic [31:0] adr;
        logic [31:0] rs;
        logic [31:0] pc;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    obs_t        o;
    obs_t        e;
    vec_t        tbl[14];
    logic [31:0] m_pc;
    logic [3:0]  m_flags;

    task automatic chk(input string tag, input int idx, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL [%s #%0d] %s: got %h, expected %h", tag, idx, name, act, exp);
        end
    endtask

    // Drive one instruction starting in a FETCH cycle (called #1 after a
    // posedge) and observe it until the next FETCH.
    task automatic run_instr(input logic [31:0] ins, input logic [31:0] res,
                             input logic [3:0] fl);
        int cyc;
        cyc = 0;
        bus.RD       = ins;
        bus.Result   = res;
        bus.ALUFlags = fl;
        o = '{default: 32'd0};
        do begin
            @(negedge clk);
            cyc++;
            if (bus.WE3) begin
                o.we = o.we + 32'd1;
                o.a3 = 32'(bus.A3);
            end
            if (bus.MemWrite)  o.mw  = o.mw  + 32'd1;
            if (bus.AdrSrc)    o.adr = o.adr + 32'd1;
            if (bus.ResultSrc) o.rs  = o.rs  + 32'd1;
            if (cyc == 2) begin
                o.code = 32'(bus.InstrCode);
                o.r15  = bus.R15;
                o.a1   = 32'(bus.A1);
                o.a2   = 32'(bus.A2);
                o.cmd  = 32'(bus.ALUCmd);
                o.srcb = 32'(bus.ALUSrcB);
            end
            @(posedge clk);
            #1;
        end while (!bus.IRWrite && cyc < 12);
        o.cyc = 32'(cyc);
        o.pc  = bus.PC;
        if (!bus.IRWrite) begin
            n_tests++;
            n_fail++;
            $display("FAIL [timeout] instr %h never returned to fetch", ins);
        end
    endtask

    // Instruction-level reference: outcome of one instruction from the
    // architectural rules, given the model PC and flags.
    task automatic model_step(input logic [31:0] ins, input logic [31:0] res,
                              input logic [3:0] fl);
        logic n, z, c, v;
        bit   pass;
        int   op;
        {n, z, c, v} = m_flags;
        case (ins[31:28])
            4'h0: pass = z;
            4'h1: pass = !z;
            4'h2: pass = c;
            4'h3: pass = !c;
            4'h4: pass = n;
            4'h5: pass = !n;
            4'h6: pass = v;
            4'h7: pass = !v;
            4'h8: pass = c && !z;
            4'h9: pass = !c || z;
            4'hA: pass = (n == v);
            4'hB: pass = (n != v);
            4'hC: pass = !z && (n == v);
            4'hD: pass = z || (n != v);
            4'hE: pass = 1'b1;
            default: pass = 1'b0;
        endcase
        op = int'(ins[27:26]);
        e = '{default: 32'd0};
        e.cyc  = 2;
        e.code = 6;
        e.pc   = m_pc + 32'd4;
        e.r15  = m_pc + 32'd8;
        e.a1   = (op == 2) ? 32'd15 : 32'(ins[19:16]);
        e.a2   = (op == 1 && !ins[20]) ? 32'(ins[15:12]) : 32'(ins[3:0]);
        e.cmd  = (op == 0) ? 32'(ins[24:21]) : ((op == 1 && !ins[23]) ? 32'd2 : 32'd4);
        e.srcb = (op == 0) ? 32'(ins[25]) : 32'(op);
        if (pass && op != 3) begin
            if (op == 0) begin
                e.cyc  = 4;
                e.code = ins[25] ? 32'd1 : 32'd0;
                e.we   = (ins[24:21] >= 4'd8 && ins[24:21] <= 4'd11) ? 32'd0 : 32'd1;
                if (ins[20]) m_flags = fl;
            end else if (op == 1) begin
                if (ins[20]) begin
                    e.cyc = 5; e.code = 2; e.we = 1; e.adr = 2; e.rs = 1;
                end else begin
                    e.cyc = 4; e.code = 3; e.mw = 1; e.adr = 1;
                end
            end else begin
                e.cyc  = 3;
                e.code = ins[24] ? 32'd7 : 32'd4;
                e.pc   = res;
            end
            if (e.we != 0 && ins[15:12] == 4'd15) e.pc = res;
        end
        e.a3 = 32'(ins[15:12]);
        m_pc = e.pc;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL [watchdog] simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] prev_pc;
        logic [31:0] ins;
        logic [31:0] res;
        logic [3:0]  fl;
        bit          found;

        //            instr          res            fl     cyc  code we  a3   mw adr rs  pc
        tbl[0]  = '{32'hE2801005, 32'h0000_0005, 32'h0, 32'd4, 32'd1, 32'd1, 32'd1,  32'd0, 32'd0, 32'd0, 32'h0000_0004};
        tbl[1]  = '{32'hE0510002, 32'h0000_0000, 32'h4, 32'd4, 32'd0, 32'd1, 32'd0,  32'd0, 32'd0, 32'd0, 32'h0000_0008};
        tbl[2]  = '{32'h0A000002, 32'h0000_0040, 32'h0, 32'd3, 32'd4, 32'd0, 32'd0,  32'd0, 32'd0, 32'd0, 32'h0000_0040};
        tbl[3]  = '{32'hE0510002, 32'h0000_0000, 32'h0, 32'd4, 32'd0, 32'd1, 32'd0,  32'd0, 32'd0, 32'd0, 32'h0000_0044};
        tbl[4]  = '{32'h0A000002, 32'h0000_0080, 32'h0, 32'd2, 32'd6, 32'd0, 32'd0,  32'd0, 32'd0, 32'd0, 32'h0000_0048};
        tbl[5]  = '{32'hE5912004, 32'h0000_1004, 32'h0, 32'd5, 32'd2, 32'd1, 32'd2,  32'd0, 32'd2, 32'd1, 32'h0000_004C};
        tbl[6]  = '{32'hE5812004, 32'h0000_1004, 32'h0, 32'd4, 32'd3, 32'd0, 32'd0,  32'd1, 32'd1, 32'd0, 32'h0000_0050};
        tbl[7]  = '{32'hE1500001, 32'h0000_0000, 32'h6, 32'd4, 32'd0, 32'd0, 32'd0,  32'd0, 32'd0, 32'd0, 32'h0000_0054};
        tbl[8]  = '{32'h1A000000, 32'h0000_0300, 32'h0, 32'd2, 32'd6, 32'd0, 32'd0,  32'd0, 32'd0, 32'd0, 32'h0000_0058};
        tbl[9]  = '{32'hE1A0F00E, 32'h0000_0100, 32'h0, 32'd4, 32'd0, 32'd1, 32'd15, 32'd0, 32'd0, 32'd0, 32'h0000_0100};
        tbl[10] = '{32'hEA000000, 32'h0000_0020, 32'h0, 32'd3, 32'd4, 32'd0, 32'd0,  32'd0, 32'd0, 32'd0, 32'h0000_0020};
        tbl[11] = '{32'hEB000010, 32'h0000_0200, 32'h0, 32'd3, 32'd7, 32'd0, 32'd0,  32'd0, 32'd0, 32'd0, 32'h0000_0200};
        tbl[12] = '{32'hF0000000, 32'h0000_0000, 32'h0, 32'd2, 32'd6, 32'd0, 32'd0,  32'd0, 32'd0, 32'd0, 32'h0000_0204};
        tbl[13] = '{32'hEC000000, 32'h0000_0000, 32'h0, 32'd2, 32'd6, 32'd0, 32'd0,  32'd0, 32'd0, 32'd0, 32'h0000_0208};

        rst_n        = 1'b0;
        bus.RD       = 32'd0;
        bus.Result   = 32'd0;
        bus.ALUFlags = 4'd0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("reset", 0, "PC",       bus.PC,              32'h0000_0000);
        chk("reset", 0, "R15",      bus.R15,             32'h0000_0004);
        chk("reset", 0, "IRWrite",  32'(bus.IRWrite),    32'd0);
        chk("reset", 0, "WE3",      32'(bus.WE3),        32'd0);
        chk("reset", 0, "MemWrite", 32'(bus.MemWrite),   32'd0);
        chk("reset", 0, "AdrSrc",   32'(bus.AdrSrc),     32'd0);
        rst_n = 1'b1;
        #1;
        chk("reset", 1, "IRWrite_after_release", 32'(bus.IRWrite), 32'd1);

        // ---------------- directed vector table ----------------
        prev_pc = 32'd0;
        for (int i = 0; i < 14; i++) begin
            run_instr(tbl[i].instr, tbl[i].res, tbl[i].fl[3:0]);
            chk("vec", i, "cycles",    o.cyc,  tbl[i].cyc);
            chk("vec", i, "InstrCode", o.code, tbl[i].code);
            chk("vec", i, "WE3_count", o.we,   tbl[i].we);
            if (tbl[i].we != 0) chk("vec", i, "A3", o.a3, tbl[i].a3);
            chk("vec", i, "MemWrite_count",  o.mw,  tbl[i].mw);
            chk("vec", i, "AdrSrc_count",    o.adr, tbl[i].adr);
            chk("vec", i, "ResultSrc_count", o.rs,  tbl[i].rs);
            chk("vec", i, "PC_after",        o.pc,  tbl[i].pc);
            chk("vec", i, "R15_decode",      o.r15, prev_pc + 32'd8);
            prev_pc = tbl[i].pc;
        end

        // ---------------- PC wrap-around ----------------
        run_instr(32'hEA000000, 32'hFFFF_FFFC, 4'd0);
        chk("wrap", 0, "PC_after_branch", o.pc, 32'hFFFF_FFFC);
        run_instr(32'hF0000000, 32'h0000_0000, 4'd0);
        chk("wrap", 1, "PC_wrapped",  o.pc,  32'h0000_0000);
        chk("wrap", 1, "R15_decode",  o.r15, 32'h0000_0004);

        // ---------------- reset during MEMWRITE ----------------
        bus.RD       = 32'hE5812004;
        bus.Result   = 32'h0000_2000;
        bus.ALUFlags = 4'd0;
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            @(negedge clk);
            if (bus.MemWrite) found = 1'b1;
        end
        chk("rst_mw", 0, "MemWrite_seen", 32'(found), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mw", 0, "MemWrite_dropped", 32'(bus.MemWrite), 32'd0);
        chk("rst_mw", 0, "PC_reset",         bus.PC,            32'h0000_0000);
        chk("rst_mw", 0, "WE3_low",          32'(bus.WE3),      32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_instr(32'hF0000000, 32'h0000_0000, 4'd0);
        chk("rst_mw", 1, "cycles",         o.cyc, 32'd2);
        chk("rst_mw", 1, "MemWrite_count", o.mw,  32'd0);
        chk("rst_mw", 1, "PC_after",       o.pc,  32'h0000_0004);

        // ---------------- randomized stream vs reference ----------------
        m_pc    = 32'h0000_0004;
        m_flags = 4'd0;
        for (int i = 0; i < 300; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 9) < 7) ins[31:28] = 4'hE;
            res = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 15) == 0) res = 32'hFFFF_FFFC;
            fl = 4'($urandom_range(0, 15));
            model_step(ins, res, fl);
            run_instr(ins, res, fl);
            chk("rnd", i, "cycles",          o.cyc,  e.cyc);
            chk("rnd", i, "InstrCode",       o.code, e.code);
            chk("rnd", i, "WE3_count",       o.we,   e.we);
            if (e.we != 0) chk("rnd", i, "A3", o.a3, e.a3);
            chk("rnd", i, "MemWrite_count",  o.mw,   e.mw);
            chk("rnd", i, "AdrSrc_count",    o.adr,  e.adr);
            chk("rnd", i, "ResultSrc_count", o.rs,   e.rs);
            chk("rnd", i, "PC_after",        o.pc,   e.pc);
            chk("rnd", i, "R15_decode",      o.r15,  e.r15);
            if (ins[27:26] != 2'b11) begin
                chk("rnd", i, "A1",      o.a1,   e.a1);
                chk("rnd", i, "A2",      o.a2,   e.a2);
                chk("rnd", i, "ALUCmd",  o.cmd,  e.cmd);
                chk("rnd", i, "ALUSrcB", o.srcb, e.srcb);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
